// File: rtl/stage3_word_packer.sv
// Packs variable-length right-aligned codewords MSB-first into dense O_WIDTH-bit words.
// A flush drains the accumulator, zero-pads the tail word and tags it with o_last.
module stage3_word_packer #(
    parameter int unsigned O_WIDTH   = 64,
    parameter int unsigned LEN_WIDTH = 7,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [O_WIDTH-1:0]   i_code,
    input  logic [LEN_WIDTH-1:0] i_len,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [O_WIDTH-1:0]   o_word,
    output logic                 o_last,
    output logic                 o_done,
    output logic [CNT_WIDTH-1:0] o_word_count
);

    localparam int unsigned A_WIDTH = 2 * O_WIDTH;
    localparam int unsigned S_WIDTH = LEN_WIDTH + 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                 r_state;
    logic [A_WIDTH-1:0]     r_acc;
    logic [LEN_WIDTH-1:0]   r_fill;
    logic [CNT_WIDTH-1:0]   r_word_count;

    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic [LEN_WIDTH-1:0]   w_len_e;
    logic [A_WIDTH-1:0]     w_acc_pop;
    logic [LEN_WIDTH-1:0]   w_fill_pop;
    logic [A_WIDTH-1:0]     w_mask;
    logic [A_WIDTH-1:0]     w_code_ext;
    logic [S_WIDTH-1:0]     w_shamt;
    logic [A_WIDTH-1:0]     w_acc_push;
    logic [LEN_WIDTH-1:0]   w_fill_push;

    // Output side is decoded from registered state only; o_ready alone sees i_ready.
    assign w_full       = (r_fill >= LEN_WIDTH'(O_WIDTH));
    assign o_valid      = w_full || ((r_state == ST_FLUSH) && (r_fill != '0));
    assign o_last       = (r_state == ST_FLUSH) && (r_fill != '0) && !(r_fill > LEN_WIDTH'(O_WIDTH));
    assign o_done       = (r_state == ST_FLUSH) && (r_fill == '0);
    assign o_word       = r_acc[A_WIDTH-1 -: O_WIDTH];
    assign o_word_count = r_word_count;
    assign w_pop        = o_valid && i_ready;
    assign o_ready      = (r_state == ST_RUN) && (!w_full || w_pop);
    assign w_push       = i_valid && o_ready;
    assign w_len_e      = (i_len > LEN_WIDTH'(O_WIDTH)) ? LEN_WIDTH'(O_WIDTH) : i_len;

    // Pop first, then place the new code directly below the surviving valid bits.
    always_comb begin
        w_acc_pop   = r_acc;
        w_fill_pop  = r_fill;
        if (w_pop) begin
            w_acc_pop  = r_acc << O_WIDTH;
            w_fill_pop = w_full ? (r_fill - LEN_WIDTH'(O_WIDTH)) : '0;
        end
        w_mask      = (A_WIDTH'(1) << w_len_e) - A_WIDTH'(1);
        w_code_ext  = A_WIDTH'(i_code) & w_mask;
        w_shamt     = S_WIDTH'(A_WIDTH) - S_WIDTH'(w_fill_pop) - S_WIDTH'(w_len_e);
        w_acc_push  = w_acc_pop | (w_code_ext << w_shamt);
        w_fill_push = w_fill_pop + w_len_e;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_RUN;
            r_acc        <= '0;
            r_fill       <= '0;
            r_word_count <= '0;
        end else begin
            if (w_pop) begin
                r_word_count <= r_word_count + CNT_WIDTH'(1);
            end
            if (r_state == ST_RUN) begin
                r_acc  <= w_push ? w_acc_push : w_acc_pop;
                r_fill <= w_push ? w_fill_push : w_fill_pop;
                if (i_flush && !w_push) begin
                    r_state <= ST_FLUSH;
                end
            end else if (r_fill == '0) begin
                r_state <= ST_RUN;
                r_acc   <= '0;
            end else begin
                r_acc  <= w_acc_pop;
                r_fill <= w_fill_pop;
            end
        end
    end

endmodule
